// File: rtl/mux_select_scanner_if.sv
// Handshake and mux-stage bundle for mux_select_scanner.
//   start  : scan request from the controller
//   mask   : channel enables, bit i = channel i
//   o_in   : output of the 4x1 mux stage being scanned
//   s1, s0 : mux selects driven by the scanner
//   busy   : scan in progress
//   done   : one-cycle completion pulse, sample valid in that cycle
//   sample : snapshot word, bit i = mux output captured on channel i
//   err    : one-cycle pulse for a start with an empty mask
// master = controller/mux side, slave = scanner side.
interface mux_select_scanner_if;
    logic       start;
    logic [3:0] mask;
    logic       o_in;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       done;
    logic [3:0] sample;
    logic       err;

    modport master (
        output start, mask, o_in,
        input  s1, s0, busy, done, sample, err
    );

    modport slave (
        input  start, mask, o_in,
        output s1, s0, busy, done, sample, err
    );
endinterface

// File: rtl/mux_select_scanner.sv
// Sequencer for a 4x1 mux stage: steps the selects through every channel enabled in
// the mask (ascending), lets each path settle for DWELL cycles, captures the mux output
// in the following cycle, and returns all captured bits as one snapshot word.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset, priority over start
//   bus  : mux_select_scanner_if.slave (start/mask/o_in in; s1/s0/busy/done/sample/err out)
// Parameters:
//   DWELL : settle cycles per channel, 1..255
module mux_select_scanner #(
    parameter int unsigned DWELL = 1
) (
    input logic                 clk,
    input logic                 rst,
    mux_select_scanner_if.slave bus
);

    localparam logic [7:0] CntLast = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] sample_q, sample_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       err_q, err_d;

    logic [1:0] first_ch;
    logic [1:0] next_ch;
    logic       has_next;

    // Lowest set bit of the incoming mask; descending loop so the lowest index wins.
    always_comb begin
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mask[i]) begin
                first_ch = 2'(i);
            end
        end
    end

    // Next latched-mask channel strictly above the current one; no wrap-around.
    always_comb begin
        next_ch  = sel_q;
        has_next = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_ch  = 2'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.mask != 4'd0) begin
                        mask_d   = bus.mask;
                        sel_d    = first_ch;
                        cnt_d    = 8'd0;
                        shadow_d = 4'd0;
                        state_d  = StSettle;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CntLast) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                shadow_d[sel_q] = bus.o_in;
                if (has_next) begin
                    sel_d   = next_ch;
                    cnt_d   = 8'd0;
                    state_d = StSettle;
                end else begin
                    // Publish including the bit captured this cycle.
                    sample_d = shadow_d;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mask_q   <= 4'd0;
            shadow_q <= 4'd0;
            sample_q <= 4'd0;
            cnt_q    <= 8'd0;
            sel_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
        end
    end

    assign bus.s1     = sel_q[1];
    assign bus.s0     = sel_q[0];
    assign bus.busy   = (state_q == StSettle) || (state_q == StCapture);
    assign bus.done   = (state_q == StDone);
    assign bus.sample = sample_q;
    assign bus.err    = err_q;

endmodule
